// File: rtl/mc14500_seq.sv
// rtl/mc14500_seq.sv - mc14500 program sequencer: PC, ROM fetch, CALL/RETURN stack.
// Optional FLGF halt is enabled by defining MC14500_SEQ_FLGF_HALT_EN.
module mc14500_seq #(
  parameter int ADDR_W    = 8,
  parameter int STK_DEPTH = 4,
  parameter int RESET_VEC = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          run,
  output logic [ADDR_W-1:0]             prog_addr,
  input  logic [ADDR_W+3:0]             prog_data,
  output logic [3:0]                    icu_instr,
  output logic [ADDR_W-1:0]             icu_operand,
  output logic                          icu_valid,
  input  logic                          jmp,
  input  logic                          rtn,
  input  logic                          flg0,
  input  logic                          flgf,
  output logic [$clog2(STK_DEPTH+1)-1:0] sp,
  output logic                          stk_ovf,
  output logic                          stk_unf,
  output logic                          halted
);

  localparam int SP_W = $clog2(STK_DEPTH + 1);
  localparam logic [SP_W-1:0]   SP_FULL = SP_W'(STK_DEPTH);
  localparam logic [ADDR_W-1:0] PC_RST  = ADDR_W'(RESET_VEC);

`ifdef MC14500_SEQ_FLGF_HALT_EN
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC} state_t;
`endif

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt, pc_inc, top;
  logic [ADDR_W-1:0] stk [STK_DEPTH];
  logic              push, pop, ovf_set, unf_set, load;

  assign pc_inc = pc + ADDR_W'(1);

  always_comb begin
    top = '0;
    for (int i = 0; i < STK_DEPTH; i++)
      if (sp == SP_W'(i + 1)) top = stk[i];
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    push      = 1'b0;
    pop       = 1'b0;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;
    load      = 1'b0;
    case (state)
      S_IDLE: if (run) state_nxt = S_FETCH;
      S_FETCH: begin
        load      = 1'b1;
        state_nxt = S_EXEC;
      end
      S_EXEC: begin
        // jmp takes priority over rtn; a dropped push still takes the jump
        if (jmp) begin
          pc_nxt = icu_operand;
          if (flg0) begin
            if (sp == SP_FULL) ovf_set = 1'b1;
            else               push    = 1'b1;
          end
        end else if (rtn) begin
          if (sp == '0) begin
            unf_set = 1'b1;
            pc_nxt  = pc_inc;
          end else begin
            pop    = 1'b1;
            pc_nxt = top;
          end
        end else begin
          pc_nxt = pc_inc;
        end
        state_nxt = run ? S_FETCH : S_IDLE;
`ifdef MC14500_SEQ_FLGF_HALT_EN
        if (flgf) state_nxt = S_HALT;
`endif
      end
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= PC_RST;
      icu_instr   <= '0;
      icu_operand <= '0;
      sp          <= '0;
      stk_ovf     <= 1'b0;
      stk_unf     <= 1'b0;
      for (int i = 0; i < STK_DEPTH; i++) stk[i] <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (load) begin
        icu_instr   <= prog_data[ADDR_W+3:ADDR_W];
        icu_operand <= prog_data[ADDR_W-1:0];
      end
      for (int i = 0; i < STK_DEPTH; i++)
        if (push && sp == SP_W'(i)) stk[i] <= pc_inc;
      if (push) sp <= sp + SP_W'(1);
      if (pop)  sp <= sp - SP_W'(1);
      if (ovf_set) stk_ovf <= 1'b1;
      if (unf_set) stk_unf <= 1'b1;
    end
  end

  // During EXEC the ROM is addressed with the next PC so its word is ready by the next FETCH edge
  assign prog_addr = (state == S_EXEC) ? pc_nxt : pc;
  assign icu_valid = (state == S_EXEC);

`ifdef MC14500_SEQ_FLGF_HALT_EN
  assign halted = (state == S_HALT);
`else
  logic flgf_unused;
  assign flgf_unused = flgf;
  assign halted      = 1'b0;
`endif

endmodule

// File: tb/tb_mc14500_seq.sv
// tb/tb_mc14500_seq.sv - directed bench for mc14500_seq with a sync ROM and a tiny ICU flag model.
module tb_mc14500_seq;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_JR   = 4'hB;  // jmp and rtn together
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_RTN  = 4'hD;
  localparam logic [3:0] OP_CALL = 4'hE;
  localparam logic [3:0] OP_FLGF = 4'hF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [7:0]  prog_addr;
  logic [11:0] prog_data = '0;
  logic [3:0]  icu_instr;
  logic [7:0]  icu_operand;
  logic        icu_valid;
  logic        jmp, rtn, flg0, flgf;
  logic [2:0]  sp;
  logic        stk_ovf, stk_unf, halted;

  logic [11:0] rom [256];
  int          n_chk  = 0;
  int          n_pass = 0;

  mc14500_seq #(.ADDR_W(8), .STK_DEPTH(4), .RESET_VEC(0)) dut (
    .clk(clk), .rst(rst), .run(run),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .icu_instr(icu_instr), .icu_operand(icu_operand), .icu_valid(icu_valid),
    .jmp(jmp), .rtn(rtn), .flg0(flg0), .flgf(flgf),
    .sp(sp), .stk_ovf(stk_ovf), .stk_unf(stk_unf), .halted(halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) prog_data <= rom[prog_addr];

  assign jmp  = icu_valid && (icu_instr == OP_JMP || icu_instr == OP_CALL || icu_instr == OP_JR);
  assign flg0 = icu_valid && (icu_instr == OP_CALL);
  assign rtn  = icu_valid && (icu_instr == OP_RTN || icu_instr == OP_JR);
  assign flgf = icu_valid && (icu_instr == OP_FLGF);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic rom_clear();
    for (int i = 0; i < 256; i++) rom[i] = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Wait for the next EXEC, check the redirected address, then check sp one cycle later.
  task automatic run_exec(input string tag, input logic [7:0] exp_pc, input logic [2:0] exp_sp);
    int n;
    n = 0;
    @(negedge clk);
    while (!icu_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(icu_valid), 32'd1);
    check({tag, "_pc"}, 32'(prog_addr), 32'(exp_pc));
    @(negedge clk);
    check({tag, "_sp"}, 32'(sp), 32'(exp_sp));
  endtask

  initial begin
    logic [7:0] exp_addr [6];
    logic       exp_v    [6];
    int         bad;

    rom_clear();
    @(negedge clk);
    check("rst_addr",  32'(prog_addr), 32'h0);
    check("rst_valid", 32'(icu_valid), 32'h0);
    check("rst_instr", 32'(icu_instr), 32'h0);
    check("rst_flags", {29'd0, stk_ovf, stk_unf, halted}, 32'h0);
    check("rst_sp",    32'(sp), 32'h0);

    // linear NOPs: FETCH shows PC, EXEC shows the next PC
    exp_addr = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd2, 8'd3};
    exp_v    = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("t1_addr%0d", i), 32'(prog_addr), 32'(exp_addr[i]));
      check($sformatf("t1_v%0d", i), 32'(icu_valid), 32'(exp_v[i]));
    end

    rom_clear();
    rom[3] = {OP_JMP, 8'h40};
    do_reset();
    run = 1'b1;
    run_exec("t2_a", 8'h01, 3'd0);
    run_exec("t2_b", 8'h02, 3'd0);
    run_exec("t2_c", 8'h03, 3'd0);
    run_exec("t2_jmp", 8'h40, 3'd0);
    run_exec("t2_after", 8'h41, 3'd0);

    rom_clear();
    rom[8'h00] = {OP_JMP, 8'h10};
    rom[8'h10] = {OP_CALL, 8'h80};
    rom[8'h80] = {OP_RTN, 8'h00};
    rom[8'h12] = {OP_JR, 8'h70};
    do_reset();
    run = 1'b1;
    run_exec("t3_j", 8'h10, 3'd0);
    run_exec("t3_call", 8'h80, 3'd1);
    run_exec("t3_ret", 8'h11, 3'd0);
    run_exec("t3_nop", 8'h12, 3'd0);
    run_exec("t3_jr", 8'h70, 3'd0);
    check("t3_unf", 32'(stk_unf), 32'h0);

    rom_clear();
    rom[8'h00] = {OP_CALL, 8'h20};
    rom[8'h20] = {OP_CALL, 8'h30};
    rom[8'h30] = {OP_CALL, 8'h40};
    rom[8'h40] = {OP_CALL, 8'h50};
    rom[8'h50] = {OP_CALL, 8'h60};
    rom[8'h60] = {OP_RTN, 8'h00};
    rom[8'h41] = {OP_RTN, 8'h00};
    rom[8'h31] = {OP_RTN, 8'h00};
    rom[8'h21] = {OP_RTN, 8'h00};
    rom[8'h01] = {OP_RTN, 8'h00};
    rom[8'h02] = {OP_CALL, 8'h90};
    rom[8'h90] = {4'h1, 8'h5A};
    do_reset();
    run = 1'b1;
    run_exec("t4_c1", 8'h20, 3'd1);
    run_exec("t4_c2", 8'h30, 3'd2);
    run_exec("t4_c3", 8'h40, 3'd3);
    run_exec("t4_c4", 8'h50, 3'd4);
    check("t4_ovf0", 32'(stk_ovf), 32'h0);
    run_exec("t4_c5", 8'h60, 3'd4);
    check("t4_ovf1", 32'(stk_ovf), 32'h1);
    run_exec("t4_r1", 8'h41, 3'd3);
    run_exec("t4_r2", 8'h31, 3'd2);
    run_exec("t4_r3", 8'h21, 3'd1);
    run_exec("t4_r4", 8'h01, 3'd0);
    check("t4_unf0", 32'(stk_unf), 32'h0);
    run_exec("t4_r5", 8'h02, 3'd0);
    check("t4_unf1", 32'(stk_unf), 32'h1);
    run_exec("t4_c6", 8'h90, 3'd1);

    // asynchronous reset in the middle of EXEC
    bad = 0;
    @(negedge clk);
    while (!icu_valid && bad < 8) begin
      @(negedge clk);
      bad++;
    end
    check("t6_pre_instr", 32'(icu_instr), 32'h1);
    rst = 1'b1;
    #1;
    check("t6_addr",  32'(prog_addr), 32'h0);
    check("t6_valid", 32'(icu_valid), 32'h0);
    check("t6_instr", {20'd0, icu_instr, icu_operand}, 32'h0);
    check("t6_sp",    32'(sp), 32'h0);
    check("t6_flags", {29'd0, stk_ovf, stk_unf, halted}, 32'h0);

    rom_clear();
    rom[8'h00] = {OP_JMP, 8'hFF};
    do_reset();
    run = 1'b1;
    run_exec("t5_j", 8'hFF, 3'd0);
    run_exec("t5_wrap", 8'h00, 3'd0);
    run = 1'b0;
    run_exec("t5_last", 8'hFF, 3'd0);
    repeat (5) @(negedge clk);
    check("t5_hold_addr",  32'(prog_addr), 32'hFF);
    check("t5_hold_valid", 32'(icu_valid), 32'h0);

    rom_clear();
    rom[8'h01] = {OP_FLGF, 8'h33};
    do_reset();
    run = 1'b1;
    run_exec("t7_a", 8'h01, 3'd0);
    run_exec("t7_flgf", 8'h02, 3'd0);
`ifdef MC14500_SEQ_FLGF_HALT_EN
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (prog_addr !== 8'h02 || icu_valid !== 1'b0 || halted !== 1'b1) bad++;
    end
    check("t7_frozen", 32'(bad), 32'h0);
    check("t7_halted", 32'(halted), 32'h1);
`else
    check("t7_halted", 32'(halted), 32'h0);
    run_exec("t7_cont", 8'h03, 3'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
